mux_8x1: RTL and testbench

- Eight-input, one-output selector. Output y is the input chosen by the 3-bit select sel.
- Provides a zero-latency combinational output plus a registered copy with a valid flag, so it can sit either in a combinational path or at a pipeline stage boundary.
- Intended as a leaf datapath primitive inside larger control and datapath blocks.

---
 rtl/mux_8x1_pkg.sv | 13 +
 rtl/mux_8x1_if.sv | 27 ++
 rtl/mux_8x1_core.sv | 34 +++
 rtl/mux_8x1.sv | 64 ++++++
 tb/tb_mux_8x1.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mux_8x1_pkg.sv
// Shared constants and types for the 8:1 selector and its registered stage.
package mux_8x1_pkg;

  localparam int SEL_W  = 3;
  localparam int NUM_IN = 8;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_IN-1:0] sel_onehot(input sel_t s);
    return NUM_IN'(1) << s;
  endfunction

endpackage

// File: rtl/mux_8x1_if.sv
// Data, select and capture signals of the 8:1 selector grouped as one bus.
interface mux_8x1_if
  import mux_8x1_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0]  i0, i1, i2, i3, i4, i5, i6, i7;
  sel_t              sel;
  logic              en;
  logic [WIDTH-1:0]  y;
  logic [WIDTH-1:0]  y_q;
  logic              y_vld;
  sel_t              sel_q;
  logic [NUM_IN-1:0] sel_oh;

  modport master (
    output i0, i1, i2, i3, i4, i5, i6, i7, sel, en,
    input  y, y_q, y_vld, sel_q, sel_oh
  );

  modport slave (
    input  i0, i1, i2, i3, i4, i5, i6, i7, sel, en,
    output y, y_q, y_vld, sel_q, sel_oh
  );

endinterface

// File: rtl/mux_8x1_core.sv
// Purely combinational WIDTH-generic 8:1 selector.
module mux_8x1_core
  import mux_8x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // All eight codes are decoded; the X default only shows up for an unknown sel.
  always_comb begin
    y = 'x;
    case (sel)
      3'd0: y = i0;
      3'd1: y = i1;
      3'd2: y = i2;
      3'd3: y = i3;
      3'd4: y = i4;
      3'd5: y = i5;
      3'd6: y = i6;
      3'd7: y = i7;
    endcase
  end

endmodule

// File: rtl/mux_8x1.sv
// 8:1 selector with a zero-latency output, a one-hot select decode and a
// registered copy of the selected data carrying a valid flag.
module mux_8x1
  import mux_8x1_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic       clk,
  input logic       rst,
  mux_8x1_if.slave  bus
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] data_d, data_q;
  sel_t             sel_cap_d, sel_cap_q;
  logic             vld_d, vld_q;

  mux_8x1_core #(.WIDTH(WIDTH)) u_core (
    .i0  (bus.i0),
    .i1  (bus.i1),
    .i2  (bus.i2),
    .i3  (bus.i3),
    .i4  (bus.i4),
    .i5  (bus.i5),
    .i6  (bus.i6),
    .i7  (bus.i7),
    .sel (bus.sel),
    .y   (y_comb)
  );

  // Capture handshake: en is a one-way strobe with no back-pressure; every
  // edge with en high registers the sampled data and select, and y_vld rises
  // on the first such capture and stays high until the next reset.
  always_comb begin
    data_d    = data_q;
    sel_cap_d = sel_cap_q;
    vld_d     = vld_q;
    if (bus.en) begin
      data_d    = y_comb;
      sel_cap_d = bus.sel;
      vld_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= RST_VAL;
      sel_cap_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      sel_cap_q <= sel_cap_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.y      = y_comb;
  assign bus.sel_oh = sel_onehot(bus.sel);
  assign bus.y_q    = data_q;
  assign bus.sel_q  = sel_cap_q;
  assign bus.y_vld  = vld_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Directed and randomized checks of mux_8x1 at WIDTH=1 and WIDTH=8.
module tb_mux_8x1;

  logic clk;
  logic rst1, rst8;
  int   checks;
  int   errors;

  localparam logic [7:0] RST8 = 8'hA5;

  mux_8x1_if #(.WIDTH(1)) if1 ();
  mux_8x1_if #(.WIDTH(8)) if8 ();

  mux_8x1 #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));
  mux_8x1 #(.WIDTH(8), .RST_VAL(RST8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference data
  logic       pat1 [8];
  logic [7:0] oh_tab [8];
  logic [7:0] in8 [8];
  logic [7:0] exp_q [$];
  logic [7:0] m_yq;
  logic [2:0] m_selq;
  logic       m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8_inputs();
    if8.i0 = in8[0]; if8.i1 = in8[1]; if8.i2 = in8[2]; if8.i3 = in8[3];
    if8.i4 = in8[4]; if8.i5 = in8[5]; if8.i6 = in8[6]; if8.i7 = in8[7];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] s;
    logic       en_r, rst_r;
    checks = 0;
    errors = 0;
    pat1   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    oh_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst1 = 1'b0;
    rst8 = 1'b0;
    if1.en = 1'b0;
    if1.sel = 3'd0;
    if1.i0 = 1'b1; if1.i1 = 1'b0; if1.i2 = 1'b1; if1.i3 = 1'b0;
    if1.i4 = 1'b0; if1.i5 = 1'b0; if1.i6 = 1'b1; if1.i7 = 1'b0;
    if8.en = 1'b0;
    if8.sel = 3'd0;
    for (int k = 0; k < 8; k++) in8[k] = 8'h10 + 8'(k);
    drive8_inputs();

    // step 1: combinational select sweep and one-hot decode
    for (int k = 0; k < 8; k++) begin
      if1.sel = 3'(k);
      #5;
      chk($sformatf("y1_sel%0d", k), 32'(if1.y), 32'(pat1[k]));
      chk($sformatf("oh_sel%0d", k), 32'(if1.sel_oh), 32'(oh_tab[k]));
    end

    // step 2: reset held two cycles with en high; reset wins
    rst1 = 1'b1; if1.en = 1'b1; if1.sel = 3'd2;
    tick();
    tick();
    chk("rst_yq", 32'(if1.y_q), 32'h0);
    chk("rst_vld", 32'(if1.y_vld), 32'h0);
    chk("rst_selq", 32'(if1.sel_q), 32'h0);
    chk("rst_y_comb", 32'(if1.y), 32'h1);

    // step 3: capture after reset release
    rst1 = 1'b0; if1.sel = 3'd6;
    tick();
    chk("cap6_yq", 32'(if1.y_q), 32'h1);
    chk("cap6_selq", 32'(if1.sel_q), 32'h6);
    chk("cap6_vld", 32'(if1.y_vld), 32'h1);
    if1.sel = 3'd7;
    tick();
    chk("cap7_yq", 32'(if1.y_q), 32'h0);
    chk("cap7_selq", 32'(if1.sel_q), 32'h7);

    // step 4: en low freezes the registered stage
    if1.en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if1.sel = 3'(k);
      tick();
      chk($sformatf("hold_yq_%0d", k), 32'(if1.y_q), 32'h0);
      chk($sformatf("hold_selq_%0d", k), 32'(if1.sel_q), 32'h7);
      chk($sformatf("hold_vld_%0d", k), 32'(if1.y_vld), 32'h1);
      chk($sformatf("hold_y_%0d", k), 32'(if1.y), 32'(pat1[k]));
    end

    // step 5: WIDTH=8 capture and mid-stream reset
    rst8 = 1'b1; if8.en = 1'b0;
    tick();
    chk("w8_rst_yq", 32'(if8.y_q), 32'(RST8));
    chk("w8_rst_vld", 32'(if8.y_vld), 32'h0);
    rst8 = 1'b0; if8.sel = 3'd5; if8.en = 1'b1;
    #1;
    chk("w8_y_sel5", 32'(if8.y), 32'h15);
    tick();
    chk("w8_cap_yq", 32'(if8.y_q), 32'h15);
    chk("w8_cap_selq", 32'(if8.sel_q), 32'h5);
    chk("w8_cap_vld", 32'(if8.y_vld), 32'h1);
    rst8 = 1'b1;
    tick();
    chk("w8_mid_rst_yq", 32'(if8.y_q), 32'(RST8));
    chk("w8_mid_rst_vld", 32'(if8.y_vld), 32'h0);
    chk("w8_mid_rst_selq", 32'(if8.sel_q), 32'h0);
    chk("w8_mid_rst_y", 32'(if8.y), 32'h15);

    // step 6: randomized traffic against a reference model
    m_yq = RST8; m_selq = 3'd0; m_vld = 1'b0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 8; k++) in8[k] = 8'($urandom_range(0, 255));
      drive8_inputs();
      s     = 3'($urandom_range(0, 7));
      en_r  = ($urandom_range(0, 9) < 7);
      rst_r = ($urandom_range(0, 19) == 0);
      if8.sel = s; if8.en = en_r; rst8 = rst_r;
      #1;
      chk("rnd_y", 32'(if8.y), 32'(in8[s]));
      chk("rnd_oh", 32'(if8.sel_oh), 32'(1 << s));
      if (rst_r) begin
        m_yq = RST8; m_selq = 3'd0; m_vld = 1'b0;
      end else if (en_r) begin
        m_yq = in8[s]; m_selq = s; m_vld = 1'b1;
      end
      exp_q.push_back(m_yq);
      tick();
      chk("rnd_yq", 32'(if8.y_q), 32'(exp_q.pop_front()));
      chk("rnd_selq", 32'(if8.sel_q), 32'(m_selq));
      chk("rnd_vld", 32'(if8.y_vld), 32'(m_vld));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
